// File: rtl/mem_bank4x16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank4x16_pkg
// Purpose  : Shared sizes and FSM encodings for the 4x16 register memory.
// Revision : 1.0
// ============================================================================
package mem_bank4x16_pkg;

    localparam int C_WIDTH  = 16;
    localparam int C_DEPTH  = 4;
    localparam int C_ADDR_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage : mem_bank4x16_pkg
`default_nettype wire

// File: rtl/gmux4way16.sv
`default_nettype none
// ============================================================================
// Module   : gmux4way16
// Purpose  : Combinational 4-way word selector.
// Revision : 1.0
// ============================================================================
module gmux4way16
    import mem_bank4x16_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [WIDTH-1:0]    c,
    input  logic [WIDTH-1:0]    d,
    input  logic [C_ADDR_W-1:0] sel,
    output logic [WIDTH-1:0]    y
);

    always_comb begin
        y = a;
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

endmodule : gmux4way16
`default_nettype wire

// File: rtl/mem_bank4x16.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank4x16
// Purpose  : Four-word register memory with registered read and clear sequencer.
// Revision : 1.0
// ============================================================================
module mem_bank4x16
    import mem_bank4x16_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic                re,
    input  logic                clr,
    input  logic [C_ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]    din,
    output logic [WIDTH-1:0]    dout,
    output logic                dout_valid,
    output logic                busy
);

    state_t                r_state;
    state_t                w_state_next;
    logic [C_ADDR_W-1:0]   r_cnt;
    logic [C_ADDR_W-1:0]   w_cnt_next;
    logic [WIDTH-1:0]      r_mem [C_DEPTH];
    logic [WIDTH-1:0]      r_dout;
    logic                  r_dout_valid;

    logic                  w_mem_we;
    logic [C_ADDR_W-1:0]   w_mem_addr;
    logic [WIDTH-1:0]      w_mem_data;
    logic                  w_rd;
    logic [WIDTH-1:0]      w_rd_word;

    gmux4way16 #(
        .WIDTH (WIDTH)
    ) u_rd_mux (
        .a   (r_mem[0]),
        .b   (r_mem[1]),
        .c   (r_mem[2]),
        .d   (r_mem[3]),
        .sel (addr),
        .y   (w_rd_word)
    );

    // A clr in IDLE swallows any same-cycle we/re; CLEAR ignores all requests.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_mem_we     = 1'b0;
        w_mem_addr   = addr;
        w_mem_data   = din;
        w_rd         = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr) begin
                    w_state_next = CLEAR;
                    w_cnt_next   = '0;
                end else begin
                    w_mem_we = we;
                    w_rd     = re;
                end
            end
            CLEAR: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_cnt;
                w_mem_data = '0;
                w_cnt_next = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Mux reads the pre-edge words, so a same-address read/write is read-first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_rd;
            if (w_rd) begin
                r_dout <= w_rd_word;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = (r_state == CLEAR);

endmodule : mem_bank4x16
`default_nettype wire

// File: tb/tb_mem_bank4x16.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bank4x16
// Purpose  : Directed self-checking bench for mem_bank4x16.
// Revision : 1.0
// ============================================================================
module tb_mem_bank4x16;

    logic        clk;
    logic        reset;
    logic        we;
    logic        re;
    logic        clr;
    logic [1:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dout_valid;
    logic        busy;

    int checks;
    int errors;

    mem_bank4x16 #(
        .WIDTH (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .re         (re),
        .clr        (clr),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        we = 1'b1; re = 1'b0; addr = a; din = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_rd [4];
        logic [1:0]  rd_order [4];
        checks = 0;
        errors = 0;
        reset = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b0; addr = 2'd0; din = 16'h0;

        // Reset state
        tick(); tick();
        chk("rst_dout", {16'h0, dout}, 32'h0);
        chk("rst_valid", {31'h0, dout_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        tick();
        chk("idle_valid", {31'h0, dout_valid}, 32'h0);

        // Reset then read all four words back-to-back
        for (int i = 0; i < 4; i++) begin
            re = 1'b1; addr = 2'(i);
            tick();
            chk($sformatf("rst_rd%0d_dout", i), {16'h0, dout}, 32'h0);
            chk($sformatf("rst_rd%0d_valid", i), {31'h0, dout_valid}, 32'h1);
        end
        re = 1'b0;
        tick();
        chk("rd_end_valid", {31'h0, dout_valid}, 32'h0);

        // Write then read back in reverse order
        wr(2'd0, 16'h0000);
        wr(2'd1, 16'hFFFF);
        wr(2'd2, 16'hAAAA);
        wr(2'd3, 16'h5555);
        rd_order = '{2'd3, 2'd2, 2'd1, 2'd0};
        exp_rd   = '{16'h5555, 16'hAAAA, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            re = 1'b1; addr = rd_order[i];
            tick();
            chk($sformatf("wr_rd%0d_dout", i), {16'h0, dout}, {16'h0, exp_rd[i]});
            chk($sformatf("wr_rd%0d_valid", i), {31'h0, dout_valid}, 32'h1);
        end
        re = 1'b0;
        tick();
        chk("hold_valid", {31'h0, dout_valid}, 32'h0);
        chk("hold_dout", {16'h0, dout}, 32'h0);

        // Same-cycle read/write to address 2: read-first
        we = 1'b1; re = 1'b1; addr = 2'd2; din = 16'h1234;
        tick();
        chk("rw_old", {16'h0, dout}, 32'hAAAA);
        chk("rw_old_valid", {31'h0, dout_valid}, 32'h1);
        we = 1'b0;
        tick();
        chk("rw_new", {16'h0, dout}, 32'h1234);
        re = 1'b0;

        // Clear with colliding write and read; mem = 1111,FFFF,1234,5555
        wr(2'd0, 16'h1111);
        clr = 1'b1; we = 1'b1; re = 1'b1; addr = 2'd1; din = 16'hBEEF;
        tick();
        clr = 1'b0;
        chk("clr_busy0", {31'h0, busy}, 32'h1);
        chk("clr_valid0", {31'h0, dout_valid}, 32'h0);
        for (int i = 1; i < 4; i++) begin
            addr = 2'(i); clr = 1'(i == 2);
            tick();
            chk($sformatf("clr_busy%0d", i), {31'h0, busy}, 32'h1);
            chk($sformatf("clr_valid%0d", i), {31'h0, dout_valid}, 32'h0);
        end
        clr = 1'b0;
        tick();
        we = 1'b0; re = 1'b0;
        chk("clr_done_busy", {31'h0, busy}, 32'h0);
        chk("clr_done_valid", {31'h0, dout_valid}, 32'h0);
        chk("clr_dout_kept", {16'h0, dout}, 32'h1234);
        for (int i = 0; i < 4; i++) begin
            re = 1'b1; addr = 2'(i);
            tick();
            chk($sformatf("clr_rd%0d_dout", i), {16'h0, dout}, 32'h0);
            chk($sformatf("clr_rd%0d_valid", i), {31'h0, dout_valid}, 32'h1);
        end
        re = 1'b0;
        tick();

        // Reset in the second CLEAR cycle
        wr(2'd0, 16'h4444);
        wr(2'd3, 16'h7777);
        re = 1'b1; addr = 2'd3;
        tick();
        re = 1'b0;
        chk("mid_pre_dout", {16'h0, dout}, 32'h7777);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        chk("mid_busy_pre", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_dout", {16'h0, dout}, 32'h0);
        chk("mid_rst_valid", {31'h0, dout_valid}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            re = 1'b1; addr = 2'(i);
            tick();
            chk($sformatf("mid_rd%0d_dout", i), {16'h0, dout}, 32'h0);
            chk($sformatf("mid_rd%0d_busy", i), {31'h0, busy}, 32'h0);
        end
        re = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_bank4x16
`default_nettype wire

// File: doc/mem_bank4x16.md
# mem_bank4x16

Four-word, 16-bit register memory that sits directly upstream of the `gmux4way16` word selector and drives its four data inputs and 2-bit select. It provides a single write port and a registered read port. A hardware clear sequencer zeroes the four words one per cycle. It is the storage stage between the program counter/address logic and the data path, and the base element for the later larger memories.

## Interface
- `WIDTH`, 16, data word width. The depth is fixed at 4 words, with a 2-bit address.
- `clk`  in  1  single clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `we`  in  1  write enable, sampled on the clock edge.
- `re`  in  1  read enable, sampled on the clock edge.
- `clr`  in  1  clear request. Starts the 4-cycle zeroing sequence.
- `addr`  in  2  word address, shared by read and write.
- `din`  in  WIDTH  write data.
- `dout`  out  WIDTH  registered read data. Holds its value between reads.
- `dout_valid`  out  1  high for exactly one cycle when `dout` carries a newly read word.
- `busy`  out  1  high while the clear sequence runs.

## Operation
- The FSM has two states: IDLE and CLEAR.
- In IDLE, `busy` is 0.
- **Priority in IDLE:** `clr` > (`we`, `re`).
  - If `clr` is 1, enter CLEAR with the clear counter at 0. A `we` or `re` in the same cycle is dropped: no write, and `dout_valid` stays 0.
  - Otherwise, `we` and `re` act independently in the same cycle.
- **Write:** if `we`, then `mem[addr] <= din`.
- **Read:** if `re`, then `dout <= mem[addr]` (selected through the 4-way mux) and `dout_valid <= 1`. Otherwise `dout_valid <= 0` and `dout` holds its value.
- **Read and write to the same address in one cycle:** the read returns the old word (read-first).
- **CLEAR state:**
  - Each cycle, `mem[cnt] <= 0` and `cnt` increments.
  - After `cnt` == 3 is written, return to IDLE.
  - `busy` is 1 for all 4 CLEAR cycles.
  - In CLEAR, `we`, `re` and `clr` are ignored, and `dout_valid` stays 0.
  - `dout` is not cleared; it keeps its last read value.
- `cnt` is 2 bits and wraps naturally. No other arithmetic is involved.
- **Reset, asynchronous and valid at any time including mid-CLEAR:**
  - all four words = 0
  - `dout` = 0
  - `dout_valid` = 0
  - `busy` = 0
  - state = IDLE
  - `cnt` = 0

## Timing
- **Read latency:** 1 cycle. With `re` sampled at edge N, `dout` and `dout_valid` update at edge N, so they are visible in the cycle after the request.
- Back-to-back reads give `dout_valid` high on consecutive cycles.
- **Write-to-read:** a write at edge N is returned by a read sampled at edge N+1.
- **Clear:**
  - `clr` sampled at edge N sets `busy` = 1 after edge N.
  - Words 0..3 are zeroed at edges N+1..N+4.
  - `busy` = 0 after edge N+4.
  - The first accepted `we`/`re` is at edge N+5.
- The mux select path is combinational from `addr` to the `dout` register input. There is no combinational path from inputs to any output.

## Structure
- **Shared package:** `WIDTH` default (16), depth constant (4), address width (2), and state encodings IDLE = 1'b0, CLEAR = 1'b1.
- **Sub-module:** one `gmux4way16` instance selects the read word.
  - Words 0–3 connect to mux inputs a–d.
  - `addr` connects to `sel`.
  - The mux output feeds the `dout` register.
- The four word registers, the `dout`/`dout_valid` registers and the FSM/counter live in this module.

## Test plan
- **Reset then read:** assert `reset`, release it, then read `addr` 0–3. Required: `dout` = 0x0000 each cycle, with `dout_valid` pulsing 1 on each.
- **Write then read back:** write 0x0000, 0xFFFF, 0xAAAA, 0x5555 to addresses 0–3, then read 3, 2, 1, 0 back-to-back. Required: `dout` = 0x5555, 0xAAAA, 0xFFFF, 0x0000 on consecutive cycles, with `dout_valid` continuously 1.
- **Same-cycle read/write:** with `mem[2]` = 0xAAAA, issue `we` = `re` = 1, `addr` = 2, `din` = 0x1234, then read 2. Required: first `dout` = 0xAAAA, next `dout` = 0x1234.
- **Clear with a colliding write:**
  - Stimulus: with all words nonzero, pulse `clr` together with `we` (`addr` 1, `din` 0xBEEF); while `busy` is high, issue `we`/`re`; then read all words.
  - Required: `busy` is high for exactly 4 cycles, no `dout_valid` during them, all words read 0x0000, and 0xBEEF is never stored.
- **Reset mid-clear:** assert `reset` in the second CLEAR cycle. Required: `busy` = 0 and `dout` = 0 immediately, and all words read 0x0000 afterwards.
